pipeline_stall_controller: RTL and testbench



---
 rtl/pipe_ctl_pkg.sv | 19 +
 rtl/pipeline_stall_controller_sat_counter.sv | 30 +++
 rtl/pipeline_stall_controller.sv | 171 +++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctl_pkg.sv
// Shared definitions for the pipeline control slice: FSM state encodings
// and the forwarding select codes used by the hazard/forwarding unit.
package pipe_ctl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ctl_state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
  localparam logic [1:0] FWD_IN  = 2'd3;

  // Wide enough to hold the largest flush reload value (FLUSH_DEPTH-1 <= 7)
  localparam int FL_W = 4;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Generic saturating up-counter with hold and clear.
// hold has priority over clear, clear over increment; the count sticks at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Count register: freeze, clear or saturating increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (hold) begin
      count <= count;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller for the 5-stage core.
// Turns hazard stall, EX flush and memory freeze requests into per-stage
// register enables, IF/ID flush and ID/EX bubble controls. Outputs are
// Mealy so a request takes effect in the same cycle it is raised.
// Optional feature macro: STALL_PERF_EN adds stall/flush cycle counters.
module pipeline_stall_controller
  import pipe_ctl_pkg::*;
#(
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 4,
  parameter int MAX_STALL   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             flush_req,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic [1:0]       ctl_state,
`ifdef STALL_PERF_EN
  output logic [15:0]      perf_stall_cycles,
  output logic [15:0]      perf_flush_cycles,
`endif
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout
);

  localparam logic [FL_W-1:0]  FL_RELOAD   = FL_W'(FLUSH_DEPTH - 1);
  localparam bit               FLUSH_MULTI = (FLUSH_DEPTH > 1);
  localparam logic [CNT_W-1:0] WD_LIMIT    = CNT_W'(MAX_STALL - 1);

  ctl_state_t      state_q;
  logic [FL_W-1:0] fl_cnt;
  logic            do_flush;
  logic            in_flush;
  logic            do_stall;
  logic            wd_hit;

  assign ctl_state = state_q;

  // Resolve request priority: mem_busy over flush_req over hz_stall
  always_comb begin
    do_flush = 1'b0;
    in_flush = 1'b0;
    do_stall = 1'b0;
    if (!mem_busy) begin
      if (flush_req) begin
        do_flush = 1'b1;
      end else if (state_q == ST_FLUSH) begin
        in_flush = 1'b1;
      end else if (hz_stall && (state_q == ST_RUN || state_q == ST_STALL)) begin
        do_stall = 1'b1;
      end
    end
    wd_hit = do_stall && (stall_cnt >= WD_LIMIT);
  end

  // Mealy stage controls; reset forces every stage to hold a NOP
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst_n) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (do_flush || in_flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (do_stall) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Control FSM and flush extender; everything freezes while memory is busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fl_cnt  <= '0;
    end else if (!mem_busy) begin
      if (flush_req) begin
        if (FLUSH_MULTI) begin
          state_q <= ST_FLUSH;
          fl_cnt  <= FL_RELOAD;
        end else begin
          state_q <= ST_RUN;
          fl_cnt  <= '0;
        end
      end else begin
        case (state_q)
          ST_RUN, ST_STALL: begin
            state_q <= hz_stall ? ST_STALL : ST_RUN;
          end
          ST_FLUSH: begin
            if (fl_cnt <= FL_W'(1)) begin
              state_q <= ST_RUN;
              fl_cnt  <= '0;
            end else begin
              fl_cnt <= fl_cnt - 1'b1;
            end
          end
          default: begin
            state_q <= ST_RUN;
            fl_cnt  <= '0;
          end
        endcase
      end
    end
  end

  // Sticky watchdog: trips on the edge where the stall count reaches MAX_STALL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_timeout <= 1'b0;
    end else if (wd_hit) begin
      stall_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (mem_busy),
    .clr   (!do_stall),
    .inc   (do_stall),
    .count (stall_cnt)
  );

`ifdef STALL_PERF_EN
  sat_counter #(.W(16)) u_perf_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (mem_busy),
    .clr   (1'b0),
    .inc   (do_stall),
    .count (perf_stall_cycles)
  );

  sat_counter #(.W(16)) u_perf_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (mem_busy),
    .clr   (1'b0),
    .inc   (do_flush || in_flush),
    .count (perf_flush_cycles)
  );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed testbench for pipeline_stall_controller (FLUSH_DEPTH=3,
// CNT_W=4, MAX_STALL=8). Optional STALL_PERF_EN ports are covered when
// the macro is defined.
module tb_pipeline_stall_controller;

  logic        clk;
  logic        rst_n;
  logic        hz_stall;
  logic        flush_req;
  logic        mem_busy;
  logic        pc_we;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_we;
  logic        idex_bubble;
  logic        exmem_we;
  logic        memwb_we;
  logic [1:0]  ctl_state;
  logic [3:0]  stall_cnt;
  logic        stall_timeout;
`ifdef STALL_PERF_EN
  logic [15:0] perf_stall_cycles;
  logic [15:0] perf_flush_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  // {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble}
  localparam logic [6:0] O_RUN   = 7'b11111_00;
  localparam logic [6:0] O_STALL = 7'b00111_01;
  localparam logic [6:0] O_FLUSH = 7'b11111_11;
  localparam logic [6:0] O_BUSY  = 7'b00000_00;
  localparam logic [6:0] O_RESET = 7'b00000_11;

  pipeline_stall_controller #(
    .FLUSH_DEPTH (3),
    .CNT_W       (4),
    .MAX_STALL   (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hz_stall      (hz_stall),
    .flush_req     (flush_req),
    .mem_busy      (mem_busy),
    .pc_we         (pc_we),
    .ifid_we       (ifid_we),
    .ifid_flush    (ifid_flush),
    .idex_we       (idex_we),
    .idex_bubble   (idex_bubble),
    .exmem_we      (exmem_we),
    .memwb_we      (memwb_we),
    .ctl_state     (ctl_state),
`ifdef STALL_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_cycles (perf_flush_cycles),
`endif
    .stall_cnt     (stall_cnt),
    .stall_timeout (stall_timeout)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence never completes
  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic logic [6:0] outs();
    return {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble};
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic busy, input logic flush, input logic hz);
    mem_busy  = busy;
    flush_req = flush;
    hz_stall  = hz;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [6:0] o, input logic [1:0] st,
                           input logic [3:0] cnt, input logic to);
    check_output({tag, ".outs"},    16'(outs()),        16'(o));
    check_output({tag, ".state"},   16'(ctl_state),     16'(st));
    check_output({tag, ".cnt"},     16'(stall_cnt),     16'(cnt));
    check_output({tag, ".timeout"}, 16'(stall_timeout), 16'(to));
  endtask

  initial begin
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", O_RESET, 2'd0, 4'd0, 1'b0);
    rst_n = 1'b1;
    #1;
    check_all("idle", O_RUN, 2'd0, 4'd0, 1'b0);

    // Two-cycle load-use stall
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_all("stall.c0", O_STALL, 2'd0, 4'd0, 1'b0);
    tick();
    check_all("stall.c1", O_STALL, 2'd1, 4'd1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_all("stall.release", O_RUN, 2'd1, 4'd1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    tick();
    check_all("stall.c2", O_STALL, 2'd1, 4'd2, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_all("stall.drop", O_RUN, 2'd1, 4'd2, 1'b0);
    tick();
    check_all("stall.back", O_RUN, 2'd0, 4'd0, 1'b0);

    // Single flush pulse extended to three cycles
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_all("flush.c0", O_FLUSH, 2'd0, 4'd0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_all("flush.c1", O_FLUSH, 2'd2, 4'd0, 1'b0);
    tick();
    check_all("flush.c2", O_FLUSH, 2'd2, 4'd0, 1'b0);
    tick();
    check_all("flush.done", O_RUN, 2'd0, 4'd0, 1'b0);

    // Flush and stall together: flush wins, stall request ignored in FLUSH
    apply_stimulus(1'b0, 1'b1, 1'b1);
    check_all("fl_hz.c0", O_FLUSH, 2'd0, 4'd0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_all("fl_hz.c1", O_FLUSH, 2'd2, 4'd0, 1'b0);
    tick();
    check_all("fl_hz.c2", O_FLUSH, 2'd2, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    tick();
    check_all("fl_hz.done", O_RUN, 2'd0, 4'd0, 1'b0);

    // Memory freeze during the second FLUSH-state cycle, four cycles long
    apply_stimulus(1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_all("busy.c1", O_BUSY, 2'd2, 4'd0, 1'b0);
    repeat (3) tick();
    check_all("busy.c4", O_BUSY, 2'd2, 4'd0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_all("busy.resume", O_FLUSH, 2'd2, 4'd0, 1'b0);
    tick();
    check_all("busy.done", O_RUN, 2'd0, 4'd0, 1'b0);

    // Watchdog: eight consecutive stalls trip the sticky flag
    apply_stimulus(1'b0, 1'b0, 1'b1);
    repeat (7) tick();
    check_all("wd.c7", O_STALL, 2'd1, 4'd7, 1'b0);
    tick();
    check_all("wd.c8", O_STALL, 2'd1, 4'd8, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    tick();
    check_all("wd.hold", O_BUSY, 2'd1, 4'd8, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    tick();
    check_all("wd.sticky", O_RUN, 2'd0, 4'd0, 1'b1);

`ifdef STALL_PERF_EN
    // Stall cycles: 2 + 8; flush cycles: 3 + 3 + 3 (busy cycles excluded)
    check_output("perf.stall", perf_stall_cycles, 16'd10);
    check_output("perf.flush", perf_flush_cycles, 16'd9);
`endif

    // Asynchronous reset in the middle of a stall
    apply_stimulus(1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    check_all("rst.pre", O_STALL, 2'd1, 4'd2, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all("rst.async", O_RESET, 2'd0, 4'd0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_all("rst.after", O_RUN, 2'd0, 4'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
